// File: rtl/modexp_engine.sv
// Iterative right-to-left modular exponentiator: result = base^exponent mod modulo.
// Two shift-add interleaved modular multipliers share each exponent-bit step.
module modexp_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] modulo,
    input  logic [WIDTH-1:0] exponent,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] base_reg;
    logic [WIDTH-1:0] mod_reg;
    logic [WIDTH-1:0] exp_reg;
    logic [WIDTH-1:0] res_reg;
    logic             err_reg;
    logic [WIDTH:0]   p_a;
    logic [WIDTH:0]   p_b;
    logic [WIDTH:0]   step_a;
    logic [WIDTH:0]   step_b;
    logic [CW-1:0]    cnt;

    // One MSB-first step; p and b are both below m, so WIDTH+1 bits suffice.
    function automatic logic [WIDTH:0] mm_step(
        input logic [WIDTH:0]   p,
        input logic [WIDTH-1:0] b,
        input logic             bit_i,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] mm;
        mm = {1'b0, m};
        t  = p << 1;
        if (t >= mm) t = t - mm;
        if (bit_i) t = t + {1'b0, b};
        if (t >= mm) t = t - mm;
        return t;
    endfunction

    assign step_a = mm_step(p_a, base_reg, res_reg[cnt], mod_reg);
    assign step_b = mm_step(p_b, base_reg, base_reg[cnt], mod_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            base_reg <= '0;
            mod_reg  <= '0;
            exp_reg  <= '0;
            res_reg  <= '0;
            err_reg  <= 1'b0;
            p_a      <= '0;
            p_b      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_reg <= base;
                        mod_reg  <= modulo;
                        exp_reg  <= exponent;
                        res_reg  <= (modulo == WIDTH'(1)) ? '0 : WIDTH'(1);
                        err_reg  <= 1'b0;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (mod_reg == '0 || base_reg >= mod_reg) begin
                        err_reg <= 1'b1;
                        res_reg <= '0;
                        state   <= S_DONE;
                    end else if (exp_reg == '0) begin
                        state <= S_DONE;
                    end else begin
                        p_a   <= '0;
                        p_b   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    p_a <= step_a;
                    p_b <= step_b;
                    if (cnt == '0) state <= S_UPD;
                    else cnt <= cnt - 1'b1;
                end
                S_UPD: begin
                    if (exp_reg[0]) res_reg <= p_a[WIDTH-1:0];
                    base_reg <= p_b[WIDTH-1:0];
                    exp_reg  <= exp_reg >> 1;
                    state    <= S_SCAN;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready  = (state == S_IDLE);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign err    = err_reg;
    assign result = res_reg;

endmodule
